// File: rtl/minimal_des_axi_slave.sv
// AXI4-Lite register slave for the minimal DES core: key/data/control registers,
// a one-cycle start pulse to the core, and result capture with busy/done status.
module minimal_des_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [63:0]                     des_key,
  output logic [63:0]                     des_din,
  output logic                            des_decrypt,
  output logic                            des_start,
  input  logic                            des_done,
  input  logic [63:0]                     des_dout
);

  localparam logic [2:0] A_KEY_HI  = 3'd0;
  localparam logic [2:0] A_KEY_LO  = 3'd1;
  localparam logic [2:0] A_DATA_HI = 3'd2;
  localparam logic [2:0] A_DATA_LO = 3'd3;
  localparam logic [2:0] A_CTRL    = 3'd4;
  localparam logic [2:0] A_STATUS  = 3'd5;
  localparam logic [2:0] A_RES_HI  = 3'd6;
  localparam logic [2:0] A_RES_LO  = 3'd7;

  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] key_hi_q, key_hi_d, key_lo_q, key_lo_d;
  logic [31:0] din_hi_q, din_hi_d, din_lo_q, din_lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        decrypt_q, decrypt_d, busy_q, busy_d, done_q, done_d;
  logic        start_q, start_d;

  logic        wr_en, rd_en, start_req;
  logic [2:0]  wr_addr, rd_addr;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  assign wr_addr   = S_AXI_AWADDR[4:2];
  assign rd_addr   = S_AXI_ARADDR[4:2];
  assign wr_en     = awready_q && wready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en     = arready_q && S_AXI_ARVALID;
  assign start_req = wr_en && (wr_addr == A_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  always_comb begin
    awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
    wready_d  = awready_d;
    bvalid_d  = bvalid_q;
    arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    key_hi_d  = key_hi_q;
    key_lo_d  = key_lo_q;
    din_hi_d  = din_hi_q;
    din_lo_d  = din_lo_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    decrypt_d = decrypt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    start_d   = 1'b0;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_en) begin
      bvalid_d = 1'b1;
      unique case (wr_addr)
        A_KEY_HI:  key_hi_d = strb_merge(key_hi_q, S_AXI_WDATA, S_AXI_WSTRB);
        A_KEY_LO:  key_lo_d = strb_merge(key_lo_q, S_AXI_WDATA, S_AXI_WSTRB);
        A_DATA_HI: din_hi_d = strb_merge(din_hi_q, S_AXI_WDATA, S_AXI_WSTRB);
        A_DATA_LO: din_lo_d = strb_merge(din_lo_q, S_AXI_WDATA, S_AXI_WSTRB);
        A_CTRL:    if (S_AXI_WSTRB[0]) decrypt_d = S_AXI_WDATA[1];
        default: ;
      endcase
    end

    // Completion wins over a same-cycle start because busy is sampled pre-update.
    if (des_done && busy_q) begin
      res_hi_d = des_dout[63:32];
      res_lo_d = des_dout[31:0];
      busy_d   = 1'b0;
      done_d   = 1'b1;
    end else if (start_req && !busy_q) begin
      busy_d  = 1'b1;
      done_d  = 1'b0;
      start_d = 1'b1;
    end

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      unique case (rd_addr)
        A_KEY_HI:  rdata_d = key_hi_q;
        A_KEY_LO:  rdata_d = key_lo_q;
        A_DATA_HI: rdata_d = din_hi_q;
        A_DATA_LO: rdata_d = din_lo_q;
        A_CTRL:    rdata_d = {30'd0, decrypt_q, 1'b0};
        A_STATUS:  rdata_d = {30'd0, done_q, busy_q};
        A_RES_HI:  rdata_d = res_hi_q;
        A_RES_LO:  rdata_d = res_lo_q;
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      key_hi_q  <= 32'd0;
      key_lo_q  <= 32'd0;
      din_hi_q  <= 32'd0;
      din_lo_q  <= 32'd0;
      res_hi_q  <= 32'd0;
      res_lo_q  <= 32'd0;
      decrypt_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      key_hi_q  <= key_hi_d;
      key_lo_q  <= key_lo_d;
      din_hi_q  <= din_hi_d;
      din_lo_q  <= din_lo_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      decrypt_q <= decrypt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign des_key       = {key_hi_q, key_lo_q};
  assign des_din       = {din_hi_q, din_lo_q};
  assign des_decrypt   = decrypt_q;
  assign des_start     = start_q;

endmodule

// File: tb/tb_minimal_des_axi_slave.sv
// Directed bench for minimal_des_axi_slave: register access, byte strobes,
// start/done handshake with the core, backpressure and reset while busy.
module tb_minimal_des_axi_slave;
  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [63:0] des_key, des_din, des_dout = '0;
  logic        des_decrypt, des_start, des_done = 1'b0;
  int tests = 0, fails = 0, start_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (des_start) start_cnt++;

  minimal_des_axi_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .des_key(des_key), .des_din(des_din), .des_decrypt(des_decrypt),
    .des_start(des_start), .des_done(des_done), .des_dout(des_dout)
  );

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    ok = 1'b0; resp = 2'bxx;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bvalid) begin ok = 1'b1; resp = bresp; break; end
        @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    ok = 1'b0; d = 'x; resp = 2'bxx;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    arvalid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (rvalid) begin ok = 1'b1; d = rdata; resp = rresp; break; end
        @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  task automatic pulse_done(input logic [63:0] v);
    @(negedge clk);
    des_done = 1'b1; des_dout = v;
    @(negedge clk);
    des_done = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, des_start, des_decrypt} !== 7'd0) begin
      fails++; $display("FAIL reset_ctl got %b want 0", {awready, wready, bvalid, arready, rvalid, des_start, des_decrypt});
    end
    tests++;
    if (rdata !== 32'd0 || des_key !== 64'd0 || des_din !== 64'd0) begin
      fails++; $display("FAIL reset_data rdata=%h key=%h din=%h want 0", rdata, des_key, des_din);
    end
  endtask

  task automatic test_regs;
    logic [1:0] r; logic [31:0] d; bit ok;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i*4), 32'(i+1), 4'hF, r, ok);
      tests++;
      if (!ok || r !== 2'b00) begin fails++; $display("FAIL wr_resp[%0d] ok=%0d got %b want 00", i, ok, r); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i*4), d, r, ok);
      tests++;
      if (!ok || d !== 32'(i+1) || r !== 2'b00) begin
        fails++; $display("FAIL rd_reg[%0d] ok=%0d got %h/%b want %h/00", i, ok, d, r, 32'(i+1));
      end
    end
    tests++;
    if (des_key !== 64'h00000001_00000002 || des_din !== 64'h00000003_00000004) begin
      fails++; $display("FAIL des_bus key=%h din=%h want 1_2/3_4", des_key, des_din);
    end
  endtask

  task automatic test_wstrb;
    logic [1:0] r; logic [31:0] d; bit ok;
    axi_write(5'h00, 32'hAABBCCDD, 4'b0010, r, ok);
    axi_read(5'h00, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0000CC01) begin fails++; $display("FAIL wstrb got %h want 0000cc01", d); end
  endtask

  task automatic test_start_done;
    logic [1:0] r; logic [31:0] d; bit ok; int c0;
    c0 = start_cnt;
    axi_write(5'h10, 32'h1, 4'h1, r, ok);
    repeat (3) @(negedge clk);
    tests++;
    if (start_cnt !== c0 + 1) begin fails++; $display("FAIL start_pulse got %0d cycles want 1", start_cnt - c0); end
    axi_read(5'h14, d, r, ok);
    tests++;
    if (!ok || d !== 32'h1) begin fails++; $display("FAIL status_busy got %h want 1", d); end
    pulse_done(64'h0123456789ABCDEF);
    axi_read(5'h14, d, r, ok);
    tests++;
    if (!ok || d !== 32'h2) begin fails++; $display("FAIL status_done got %h want 2", d); end
    axi_read(5'h18, d, r, ok);
    tests++;
    if (!ok || d !== 32'h01234567) begin fails++; $display("FAIL res_hi got %h want 01234567", d); end
    axi_read(5'h1C, d, r, ok);
    tests++;
    if (!ok || d !== 32'h89ABCDEF) begin fails++; $display("FAIL res_lo got %h want 89abcdef", d); end
  endtask

  task automatic test_busy_start;
    logic [1:0] r; logic [31:0] d; bit ok; int c0;
    axi_write(5'h10, 32'h1, 4'h1, r, ok);
    c0 = start_cnt;
    axi_write(5'h10, 32'h3, 4'h1, r, ok);
    repeat (3) @(negedge clk);
    tests++;
    if (start_cnt !== c0) begin fails++; $display("FAIL busy_start got %0d pulses want 0", start_cnt - c0); end
    axi_read(5'h14, d, r, ok);
    tests++;
    if (!ok || d !== 32'h1 || des_decrypt !== 1'b1) begin
      fails++; $display("FAIL busy_status got %h dec=%b want 1 dec=1", d, des_decrypt);
    end
    pulse_done(64'hFEDCBA9876543210);
    pulse_done(64'h1111111122222222);
    axi_read(5'h18, d, r, ok);
    tests++;
    if (!ok || d !== 32'hFEDCBA98) begin fails++; $display("FAIL idle_done got %h want fedcba98", d); end
    axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, r, ok);
    tests++;
    if (!ok || r !== 2'b00) begin fails++; $display("FAIL ro_bresp ok=%0d got %b want 00", ok, r); end
    axi_read(5'h1C, d, r, ok);
    tests++;
    if (!ok || d !== 32'h76543210) begin fails++; $display("FAIL ro_write got %h want 76543210", d); end
  endtask

  task automatic test_backpressure;
    logic [1:0] r; logic [31:0] d; bit ok; int bad;
    // Address without data must not be accepted.
    @(negedge clk);
    awaddr = 5'h0C; awvalid = 1'b1; bad = 0;
    repeat (4) begin @(negedge clk); if (awready || wready) bad++; end
    awvalid = 1'b0;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL aw_only got %0d accepting cycles want 0", bad); end
    // Write accepted, then BREADY held low with a second write pending.
    wdata = 32'h44; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (awready) begin ok = 1'b1; break; end end
    @(negedge clk);
    wdata = 32'h66; bad = 0;
    repeat (5) begin @(negedge clk); if (!bvalid || awready || wready) bad++; end
    awvalid = 1'b0; wvalid = 1'b0;
    tests++;
    if (!ok || bad != 0) begin fails++; $display("FAIL b_hold ok=%0d got %0d bad cycles want 0", ok, bad); end
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    axi_read(5'h0C, d, r, ok);
    tests++;
    if (!ok || d !== 32'h44) begin fails++; $display("FAIL b_hold_data got %h want 44", d); end
    // Read response held while RREADY low.
    araddr = 5'h04; arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (arready) begin ok = 1'b1; break; end end
    @(negedge clk);
    arvalid = 1'b0; bad = 0;
    repeat (5) begin @(negedge clk); if (!rvalid || rdata !== 32'h2) bad++; end
    tests++;
    if (!ok || bad != 0) begin fails++; $display("FAIL r_hold ok=%0d got %0d bad cycles want 0", ok, bad); end
    rready = 1'b1; @(negedge clk); rready = 1'b0;
    tests++;
    if (rvalid !== 1'b0) begin fails++; $display("FAIL r_release got rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_same_cycle;
    logic [1:0] r; logic [31:0] d; bit ok;
    @(negedge clk);
    awaddr = 5'h08; araddr = 5'h08; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (awready && arready) begin ok = 1'b1; break; end end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tests++;
    if (!ok || !rvalid || !bvalid || rdata !== 32'h3) begin
      fails++; $display("FAIL same_cycle ok=%0d rv=%b bv=%b got %h want 3", ok, rvalid, bvalid, rdata);
    end
    bready = 1'b1; rready = 1'b1; @(negedge clk); bready = 1'b0; rready = 1'b0;
    axi_read(5'h08, d, r, ok);
    tests++;
    if (!ok || d !== 32'h55) begin fails++; $display("FAIL same_cycle_wr got %h want 55", d); end
  endtask

  task automatic test_reset_busy;
    logic [1:0] r; logic [31:0] d; bit ok;
    axi_write(5'h10, 32'h3, 4'h1, r, ok);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, des_start, des_decrypt} !== 7'd0 || des_key !== 64'd0) begin
      fails++; $display("FAIL async_rst ctl=%b key=%h want 0", {awready, wready, bvalid, arready, rvalid, des_start, des_decrypt}, des_key);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_done(64'hDEADBEEFCAFEF00D);
    axi_read(5'h14, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0) begin fails++; $display("FAIL rst_status got %h want 0", d); end
    axi_read(5'h18, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0) begin fails++; $display("FAIL rst_result got %h want 0", d); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_regs;
    test_wstrb;
    test_start_done;
    test_busy_start;
    test_backpressure;
    test_same_cycle;
    test_reset_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
